uart_rx_os16: RTL and testbench
===============================

Name: uart_rx_os16

Overview:
Synthesizable 8N1 UART receiver with 16x oversampling for the BM13xx chip-chain response line. It recovers bytes from the asynchronous rxd pin and presents them on a single-entry valid/ready output buffer to the AXI-side RX FIFO logic. It reports start-glitch, framing and overrun errors. The nominal operating point is 3.125 Mbaud from a 50 MHz clock (baud_div = 0).

Parameters:
DIV_WIDTH, 12, width of the baud divisor input.
SYNC_STAGES, 2, number of flip-flops in the rxd synchronizer (minimum 2).

Ports:
clk  input  1  core clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  receiver enable; low forces IDLE.
baud_div  input  DIV_WIDTH  oversample tick every baud_div+1 clocks; bit time is 16*(baud_div+1) clocks.
rxd  input  1  asynchronous serial input; idle level is high.
m_data  output  8  received byte.
m_valid  output  1  m_data holds an unconsumed byte.
m_ready  input  1  consumer accepts m_data.
err_start  output  1  one-clock pulse: start bit rejected.
err_frame  output  1  one-clock pulse: stop bit sampled low.
err_overrun  output  1  one-clock pulse: good byte dropped because the buffer is full.
busy  output  1  high when state != IDLE.

Behaviour:
- Reset values:
  - Synchronizer flops are 1. The FSM is in IDLE.
  - m_data = 0x00, m_valid = 0; all err_* = 0; busy = 0.
  - Divisor counter, sample counter, bit counter and shift register are all 0.
- Synchronizer: rxd passes through SYNC_STAGES flops, giving rxd_s. A previous-value register rxd_q detects a falling edge (rxd_q = 1, rxd_s = 0).
- Tick generator:
  - The counter runs only when not in IDLE. It counts 0..baud_div_l; a tick is asserted in the cycle where count == baud_div_l, and the counter then wraps to 0.
  - baud_div_l latches baud_div on start detection. A baud_div change mid-frame has no effect until the next frame.
- Sample counter s (4 bits): increments on each tick and wraps 15 -> 0. The samples taken at the ticks where s = 7, 8, 9 feed a 2-of-3 majority vote.
- FSM:
  - IDLE: when enable = 1 and a falling edge is detected, go to START and clear the divisor counter, s and the bit counter.
  - START: at the tick where s = 15, if the majority is 0, go to DATA. Otherwise pulse err_start and go to IDLE.
  - DATA: at each tick where s = 15, shift the majority bit in, LSB first. After the 8th bit, go to STOP.
  - STOP: decision is made at the tick where s = 9, i.e. mid-bit, giving an early return so the next start bit is not missed.
    - Majority 1: the byte is good and is delivered to the buffer. Go to IDLE.
    - Majority 0: pulse err_frame, discard the byte, go to IDLE. A new start needs a 1->0 edge, so a held-low line does not retrigger.
- enable = 0 in any state: go to IDLE next cycle. No pulse is generated and the output buffer is unaffected.
- Output buffer:
  - A good byte with m_valid = 0: m_data <= byte and m_valid <= 1 on the next edge. Latency is 1 clock after the stop-decision tick.
  - m_valid & m_ready with no new byte: m_valid <= 0. m_data holds its value.
  - Good byte in the same cycle as m_valid & m_ready: load the new byte, m_valid stays 1, no overrun.
  - Good byte with m_valid & !m_ready: drop the new byte, keep the old m_data, pulse err_overrun.
  - m_data is stable while m_valid = 1 and m_ready = 0.
- Tolerance: ±3% baud mismatch between the sender and baud_div must be received error-free.
- rst_n asserted at any time (including mid-frame): all state takes its reset values immediately. After release, the receiver waits for a fresh falling edge.

Test Plan:
- clk 50 MHz, baud_div = 0, send 0xA5 with 8N1 at 320 ns/bit -> m_data = 0xA5 and m_valid = 1, held until m_ready. No err_* pulses.
- Back-to-back 0x00 then 0xFF with no idle gap, m_ready tied 1 -> two deliveries, 0x00 then 0xFF, no errors.
- rxd low for 80 ns (4 clocks) then high -> exactly one err_start pulse, m_valid stays 0, busy returns to 0.
- Frame 0x3C with the stop bit driven low -> err_frame pulse and no m_valid. A subsequent 0x55 frame is received correctly.
- m_ready = 0; send 0x11 then 0x22 -> m_data stays 0x11, exactly one err_overrun pulse. After m_ready = 1, m_valid drops.
- clk 100 MHz, baud_div = 1; send 0x96 at 3.125 Mbaud -3%, then at +3% -> both received. Then pulse rst_n low during data bit 4 -> all outputs at reset values. The next 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver, 16x oversampled, 2-of-3 mid-bit vote,
// single-entry valid/ready output buffer with error pulses.
module uart_rx_os16 #(
  parameter int DIV_WIDTH   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rxd,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 err_start,
  output logic                 err_frame,
  output logic                 err_overrun,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic                   rxd_q;
  logic                   fall;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic [DIV_WIDTH-1:0]   baud_div_l;
  logic [3:0]             s_cnt;
  logic [2:0]             bit_cnt;
  logic [2:0]             samp_q;
  logic [7:0]             shreg;
  logic                   tick;
  logic                   v2;
  logic                   maj;
  logic                   at_s15;
  logic                   at_s9;
  logic                   start_det;
  logic                   start_bad;
  logic                   frame_bad;
  logic                   byte_ok;
  logic                   shift_en;

  assign rxd_s = sync_q[SYNC_STAGES-1];
  assign fall  = rxd_q & ~rxd_s;
  assign busy  = (state_q != IDLE);
  assign tick  = busy && (div_cnt == baud_div_l);

  // At the stop-bit decision the third sample is the live one.
  assign v2  = (s_cnt == 4'd9) ? rxd_s : samp_q[2];
  assign maj = (samp_q[0] & samp_q[1]) |
               (samp_q[0] & v2) |
               (samp_q[1] & v2);

  assign at_s15 = tick && (s_cnt == 4'd15);
  assign at_s9  = tick && (s_cnt == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      rxd_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxd_q  <= rxd_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (fall) state_d = START;
        START: if (at_s15) state_d = maj ? IDLE : DATA;
        DATA:  if (at_s15 && bit_cnt == 3'd7) state_d = STOP;
        STOP:  if (at_s9) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    start_det = 1'b0;
    start_bad = 1'b0;
    frame_bad = 1'b0;
    byte_ok   = 1'b0;
    shift_en  = 1'b0;
    if (enable) begin
      unique case (1'b1)
        state_q == IDLE:  start_det = fall;
        state_q == START: start_bad = at_s15 && maj;
        state_q == DATA:  shift_en  = at_s15;
        state_q == STOP: begin
          byte_ok   = at_s9 && maj;
          frame_bad = at_s9 && !maj;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      baud_div_l <= '0;
      s_cnt      <= '0;
      bit_cnt    <= '0;
      samp_q     <= '0;
      shreg      <= '0;
    end else if (start_det) begin
      div_cnt    <= '0;
      baud_div_l <= baud_div;
      s_cnt      <= '0;
      bit_cnt    <= '0;
    end else if (busy) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        s_cnt <= s_cnt + 1'b1;
        if (s_cnt == 4'd7) samp_q[0] <= rxd_s;
        if (s_cnt == 4'd8) samp_q[1] <= rxd_s;
        if (s_cnt == 4'd9) samp_q[2] <= rxd_s;
      end
      if (shift_en) begin
        shreg   <= {maj, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data      <= '0;
      m_valid     <= 1'b0;
      err_start   <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_start   <= start_bad;
      err_frame   <= frame_bad;
      err_overrun <= 1'b0;
      if (byte_ok) begin
        if (!m_valid || m_ready) begin
          m_data  <= shreg;
          m_valid <= 1'b1;
        end else begin
          err_overrun <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: serial frames driven in time,
// delivered bytes checked against an expected-byte queue.
`timescale 1ns/1ps
module tb_uart_rx_os16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [11:0] baud_div = '0;
  logic        rxd = 1'b1;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        err_start;
  logic        err_frame;
  logic        err_overrun;
  logic        busy;

  real half_ns = 10.0;
  always #(half_ns) clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int c_start = 0;
  int c_frame = 0;
  int c_ovr = 0;
  logic [7:0] exp_q[$];

  uart_rx_os16 #(.DIV_WIDTH(12), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .baud_div(baud_div), .rxd(rxd),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .err_start(err_start), .err_frame(err_frame),
    .err_overrun(err_overrun), .busy(busy)
  );

  always @(negedge clk) begin
    if (err_start) c_start++;
    if (err_frame) c_frame++;
    if (err_overrun) c_ovr++;
    if (m_valid && m_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected got %h want none", m_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          n_bad++;
          $display("FAIL sb_byte got %h want %h", m_data, e);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b,
                           input real bit_ns,
                           input logic stop_bit);
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    rxd = stop_bit;
    #(bit_ns);
    rxd = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic clr_cnt();
    c_start = 0;
    c_frame = 0;
    c_ovr = 0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 m_ready = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #25;
    n_cmp += 4;
    if (m_data !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_data got %h want 00", m_data);
    end
    if (m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_valid got %b want 0", m_valid);
    end
    if ({err_start, err_frame, err_overrun} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_err got %b want 000",
               {err_start, err_frame, err_overrun});
    end
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    #13 rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_basic();
    clr_cnt();
    set_ready(1'b0);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 320.0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    n_cmp += 2;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL basic_hold got %b/%h want 1/a5",
               m_valid, m_data);
    end
    if (c_start + c_frame + c_ovr != 0) begin
      n_bad++;
      $display("FAIL basic_err got %0d want 0",
               c_start + c_frame + c_ovr);
    end
    set_ready(1'b1);
    wait_drain(200);
    #1;
    n_cmp += 2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL basic_drain got %0d want 0", exp_q.size());
    end
    if (m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_clear got %b want 0", m_valid);
    end
  endtask

  task automatic test_back_to_back();
    clr_cnt();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 320.0, 1'b1);
    send_byte(8'hFF, 320.0, 1'b1);
    wait_drain(400);
    n_cmp += 2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain got %0d want 0", exp_q.size());
    end
    if (c_start + c_frame + c_ovr != 0) begin
      n_bad++;
      $display("FAIL b2b_err got %0d want 0",
               c_start + c_frame + c_ovr);
    end
  endtask

  task automatic test_start_glitch();
    clr_cnt();
    rxd = 1'b0;
    #80;
    rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_cmp += 3;
    if (c_start != 1) begin
      n_bad++;
      $display("FAIL glitch_cnt got %0d want 1", c_start);
    end
    if (m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_valid got %b want 0", m_valid);
    end
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy got %b want 0", busy);
    end
  endtask

  task automatic test_frame_err();
    clr_cnt();
    send_byte(8'h3C, 320.0, 1'b0);
    #640;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 320.0, 1'b1);
    wait_drain(400);
    n_cmp += 3;
    if (c_frame != 1) begin
      n_bad++;
      $display("FAIL frame_cnt got %0d want 1", c_frame);
    end
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL frame_next got %0d want 0", exp_q.size());
    end
    if (c_start + c_ovr != 0) begin
      n_bad++;
      $display("FAIL frame_other got %0d want 0", c_start + c_ovr);
    end
  endtask

  task automatic test_overrun();
    clr_cnt();
    set_ready(1'b0);
    exp_q.push_back(8'h11);
    send_byte(8'h11, 320.0, 1'b1);
    send_byte(8'h22, 320.0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    n_cmp += 2;
    if (m_valid !== 1'b1 || m_data !== 8'h11) begin
      n_bad++;
      $display("FAIL ovr_hold got %b/%h want 1/11",
               m_valid, m_data);
    end
    if (c_ovr != 1) begin
      n_bad++;
      $display("FAIL ovr_cnt got %0d want 1", c_ovr);
    end
    set_ready(1'b1);
    wait_drain(100);
    #1;
    n_cmp += 2;
    if (m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_clear got %b want 0", m_valid);
    end
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL ovr_drain got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_tolerance_reset();
    clr_cnt();
    half_ns = 5.0;
    baud_div = 12'd1;
    repeat (10) @(posedge clk);
    exp_q.push_back(8'h96);
    send_byte(8'h96, 320.0 / 0.97, 1'b1);
    wait_drain(400);
    set_ready(1'b0);
    exp_q.push_back(8'h96);
    send_byte(8'h96, 320.0 / 1.03, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    n_cmp += 2;
    if (m_valid !== 1'b1 || m_data !== 8'h96) begin
      n_bad++;
      $display("FAIL tol_data got %b/%h want 1/96",
               m_valid, m_data);
    end
    if (c_start + c_frame + c_ovr != 0) begin
      n_bad++;
      $display("FAIL tol_err got %0d want 0",
               c_start + c_frame + c_ovr);
    end
    // Reset lands in data bit 4; bits 4..7 and stop are high.
    fork
      send_byte(8'hF0, 320.0, 1'b1);
      begin
        #(320.0 * 5.5);
        rst_n = 1'b0;
        #23;
        n_cmp += 3;
        if (m_valid !== 1'b0 || m_data !== 8'h00) begin
          n_bad++;
          $display("FAIL mid_rst_out got %b/%h want 0/00",
                   m_valid, m_data);
        end
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL mid_rst_busy got %b want 0", busy);
        end
        if ({err_start, err_frame, err_overrun} !== 3'b000) begin
          n_bad++;
          $display("FAIL mid_rst_err got %b want 000",
                   {err_start, err_frame, err_overrun});
        end
        rst_n = 1'b1;
      end
    join
    exp_q.delete();
    clr_cnt();
    set_ready(1'b1);
    repeat (40) @(posedge clk);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 320.0, 1'b1);
    wait_drain(400);
    n_cmp += 2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL post_rst got %0d want 0", exp_q.size());
    end
    if (c_start + c_frame + c_ovr != 0) begin
      n_bad++;
      $display("FAIL post_rst_err got %0d want 0",
               c_start + c_frame + c_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    set_ready(1'b1);
    test_back_to_back();
    test_start_glitch();
    test_frame_err();
    test_overrun();
    test_tolerance_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
